// File: rtl/op_issuer_if.sv
// Opcode issue bus between the sequencer (master) and the opcode decoder (slave).
// Carries a valid/ready handshake plus the opcode being offered.
interface op_issuer_if #(
    parameter int OP_WIDTH = 4
);
    logic                op_valid;
    logic                op_ready;
    logic [OP_WIDTH-1:0] opcode;

    modport master (output op_valid, output opcode, input op_ready);
    modport slave  (input op_valid, input opcode, output op_ready);
endinterface

// File: rtl/op_issuer.sv
// Program sequencer: fetches {rep, opcode} words and issues each opcode rep+1 times.
// Latency: start in cycle 0 -> op_valid in cycle 2; one FETCH bubble per new word.
// Backpressure: opcode/pc held with op_valid high until op_ready. Option: OP_ISSUER_LOOP_EN.
module op_issuer #(
    parameter  int OP_WIDTH  = 4,
    parameter  int REP_WIDTH = 4,
    parameter  int DEPTH     = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          prog_we,
    input  logic [AW-1:0]                 prog_addr,
    input  logic [REP_WIDTH+OP_WIDTH-1:0] prog_data,
    input  logic                          start,
`ifdef OP_ISSUER_LOOP_EN
    input  logic                          stop,
`endif
    op_issuer_if.master                   iss,
    output logic [AW-1:0]                 pc,
    output logic                          busy,
    output logic                          done
);
    localparam int W = REP_WIDTH + OP_WIDTH;
    localparam logic [OP_WIDTH-1:0] HALT    = '1;
    localparam logic [AW-1:0]       LAST_PC = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         pc_q, pc_d;
    logic [REP_WIDTH-1:0]  rep_q, rep_d;
    logic [OP_WIDTH-1:0]   opcode_q, opcode_d;
    logic [W-1:0]          mem [DEPTH];
    logic [W-1:0]          rd_q;
    logic [OP_WIDTH-1:0]   fetch_op;
    logic [REP_WIDTH-1:0]  fetch_rep;
    logic                  end_to_done;

    assign fetch_op  = rd_q[OP_WIDTH-1:0];
    assign fetch_rep = rd_q[W-1:OP_WIDTH];

    // At end of program the loop build wraps unless stop is asserted.
`ifdef OP_ISSUER_LOOP_EN
    assign end_to_done = stop;
`else
    assign end_to_done = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rep_d    = rep_q;
        opcode_d = opcode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_op == HALT) begin
                    if (end_to_done) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = '0;
                        state_d = S_FETCH;
                    end
                end else begin
                    opcode_d = fetch_op;
                    rep_d    = fetch_rep;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (iss.op_ready) begin
                    if (rep_q != '0) begin
                        rep_d = rep_q - REP_WIDTH'(1);
                    end else if (pc_q == LAST_PC) begin
                        if (end_to_done) begin
                            state_d = S_DONE;
                        end else begin
                            pc_d    = '0;
                            state_d = S_FETCH;
                        end
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            rep_q    <= '0;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rep_q    <= rep_d;
            opcode_q <= opcode_d;
        end
    end

    // Reading at the next pc makes the word available during the FETCH cycle.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
        rd_q <= mem[pc_d];
    end

    assign iss.op_valid = (state_q == S_ISSUE);
    assign iss.opcode   = opcode_q;
    assign pc           = pc_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
endmodule

// File: tb/tb_op_issuer.sv
module tb_op_issuer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic       start = 1'b0;
`ifdef OP_ISSUER_LOOP_EN
    logic       stop = 1'b1;
`endif
    logic [3:0] pc;
    logic       busy, done;

    op_issuer_if #(.OP_WIDTH(4)) iss ();

    op_issuer #(.OP_WIDTH(4), .REP_WIDTH(4), .DEPTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
`ifdef OP_ISSUER_LOOP_EN
        .stop      (stop),
`endif
        .iss       (iss),
        .pc        (pc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tb_mem [16];
    int exp_op[$];
    int exp_pc[$];
    int exp_end_pc;

    task automatic prog_word(input int addr, input logic [7:0] data);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = addr[3:0];
        prog_data = data;
        tb_mem[addr] = data;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Walk the program as a list: rep+1 issues per word, stop at HALT or the last word.
    task automatic build_model();
        int a;
        exp_op.delete();
        exp_pc.delete();
        a = 0;
        forever begin
            if (tb_mem[a][3:0] == 4'hF) break;
            for (int r = 0; r <= int'(tb_mem[a][7:4]); r++) begin
                exp_op.push_back(int'(tb_mem[a][3:0]));
                exp_pc.push_back(a);
            end
            if (a == 15) break;
            a++;
        end
        exp_end_pc = a;
    endtask

    // mode 0: always ready; 1: random ready; 2: 5-cycle stall plus start/prog_we while busy
    task automatic run_prog(input int mode, input string tag);
        int got_op[$];
        int got_pc[$];
        int dones, post, first_v, n;
        bit fin, stalled_prev;
        logic [3:0] prev_op, prev_pc;
        dones = 0; post = 0; first_v = -1; fin = 0; stalled_prev = 0;
        prev_op = '0; prev_pc = '0;
        build_model();
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            case (mode)
                0:       iss.op_ready = 1'b1;
                1:       iss.op_ready = 1'($urandom_range(0, 1));
                default: iss.op_ready = !(cyc >= 3 && cyc < 8);
            endcase
            if (mode == 2 && cyc == 4) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'hFF;
            end
            if (mode == 2 && cyc == 5) begin
                start = 1'b0; prog_we = 1'b0;
            end
            #1;
            if (stalled_prev) begin
                n_checks++;
                if (iss.op_valid !== 1'b1 || iss.opcode !== prev_op || pc !== prev_pc) begin
                    n_fail++;
                    $display("FAIL %s stall_hold: valid=%b op=%h pc=%0d, required valid=1 op=%h pc=%0d",
                             tag, iss.op_valid, iss.opcode, pc, prev_op, prev_pc);
                end
            end
            if (iss.op_valid === 1'b1 && first_v < 0) first_v = cyc;
            if (iss.op_valid === 1'b1 && iss.op_ready === 1'b1) begin
                got_op.push_back(int'(iss.opcode));
                got_pc.push_back(int'(pc));
            end
            stalled_prev = (iss.op_valid === 1'b1) && (iss.op_ready !== 1'b1);
            prev_op = iss.opcode;
            prev_pc = pc;
            if (done === 1'b1) dones++;
            if (dones > 0) post++;
            if (post == 3) fin = 1;
        end
        start = 1'b0; prog_we = 1'b0;
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("FAIL %s timeout: done seen %0d times, required run to finish", tag, dones);
        end
        n_checks++;
        if (got_op.size() != exp_op.size()) begin
            n_fail++;
            $display("FAIL %s issue_count: got %0d, required %0d", tag, got_op.size(), exp_op.size());
        end
        n = (got_op.size() < exp_op.size()) ? got_op.size() : exp_op.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (got_op[i] != exp_op[i] || got_pc[i] != exp_pc[i]) begin
                n_fail++;
                $display("FAIL %s issue[%0d]: op=%h pc=%0d, required op=%h pc=%0d",
                         tag, i, got_op[i], got_pc[i], exp_op[i], exp_pc[i]);
            end
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL %s done_pulse: high %0d cycles, required 1", tag, dones);
        end
        n_checks++;
        if (int'(pc) != exp_end_pc || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end_state: pc=%0d busy=%b, required pc=%0d busy=0", tag, pc, busy, exp_end_pc);
        end
        n_checks++;
        if (exp_op.size() > 0 && first_v != 2) begin
            n_fail++;
            $display("FAIL %s latency: first op_valid at cycle %0d, required 2", tag, first_v);
        end else if (exp_op.size() == 0 && first_v != -1) begin
            n_fail++;
            $display("FAIL %s latency: op_valid at cycle %0d, required none", tag, first_v);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (iss.op_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== 4'd0 || iss.opcode !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b pc=%0d op=%h, required all 0",
                     iss.op_valid, busy, done, pc, iss.opcode);
        end
        prog_word(0, 8'h01);
        prog_word(1, 8'h02);
        prog_word(2, 8'h0F);
        iss.op_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); iss.op_ready = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (iss.op_valid !== 1'b1 || pc !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_pre: valid=%b pc=%0d, required valid=1 pc=1", iss.op_valid, pc);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (iss.op_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b busy=%b done=%b pc=%0d, required all 0",
                     iss.op_valid, busy, done, pc);
        end
        @(negedge clk); rst_n = 1'b1;
        run_prog(0, "reset_mem_intact");
    endtask

    task automatic test_basic();
        prog_word(0, 8'h00);
        prog_word(1, 8'h02);
        prog_word(2, 8'h0F);
        run_prog(0, "basic");
    endtask

    task automatic test_repeat();
        prog_word(0, 8'h31);
        prog_word(1, 8'h0F);
        run_prog(0, "repeat");
    endtask

    task automatic test_backpressure();
        prog_word(0, 8'h27);
        prog_word(1, 8'h09);
        prog_word(2, 8'h0F);
        run_prog(2, "backpressure");
        run_prog(0, "busy_ignore");
    endtask

    task automatic test_full();
        for (int a = 0; a < 16; a++) prog_word(a, 8'h03);
        run_prog(0, "full");
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < 16; a++)
                prog_word(a, {4'($urandom_range(0, 3)), 4'($urandom_range(0, 14))});
            if ($urandom_range(0, 1) == 1) prog_word(int'($urandom_range(1, 15)), 8'h0F);
            run_prog(1, "random");
        end
    endtask

`ifdef OP_ISSUER_LOOP_EN
    task automatic test_loop();
        int got_op[$];
        int got_pc[$];
        int pat_op[3] = '{5, 5, 6};
        int pat_pc[3] = '{0, 0, 1};
        int dones, early, post;
        bit fin;
        dones = 0; early = 0; post = 0; fin = 0;
        prog_word(0, 8'h15);
        prog_word(1, 8'h06);
        prog_word(2, 8'h0F);
        stop = 1'b0;
        iss.op_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        for (int cyc = 1; cyc < 200 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (cyc == 40) stop = 1'b1;
            #1;
            if (iss.op_valid === 1'b1) begin
                got_op.push_back(int'(iss.opcode));
                got_pc.push_back(int'(pc));
            end
            if (done === 1'b1) begin
                dones++;
                if (cyc < 40) early++;
            end
            if (dones > 0) post++;
            if (post == 3) fin = 1;
        end
        n_checks++;
        if (!fin || early != 0) begin
            n_fail++;
            $display("FAIL loop_done: finished=%0d done_before_stop=%0d, required 1 and 0", fin, early);
        end
        n_checks++;
        if (got_op.size() < 6 || got_op.size() % 3 != 0) begin
            n_fail++;
            $display("FAIL loop_passes: %0d issues, required a multiple of 3 and >= 6", got_op.size());
        end
        for (int i = 0; i < got_op.size(); i++) begin
            n_checks++;
            if (got_op[i] != pat_op[i % 3] || got_pc[i] != pat_pc[i % 3]) begin
                n_fail++;
                $display("FAIL loop_issue[%0d]: op=%h pc=%0d, required op=%h pc=%0d",
                         i, got_op[i], got_pc[i], pat_op[i % 3], pat_pc[i % 3]);
            end
        end
        n_checks++;
        if (dones != 1 || pc !== 4'd2) begin
            n_fail++;
            $display("FAIL loop_end: done cycles=%0d pc=%0d, required 1 and 2", dones, pc);
        end
    endtask
`endif

    initial begin
        iss.op_ready = 1'b0;
        #23 rst_n = 1'b1;
        @(negedge clk);
        #1;
        test_reset();
        test_basic();
        test_repeat();
        test_backpressure();
        test_full();
        test_random();
`ifdef OP_ISSUER_LOOP_EN
        test_loop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
